// File: rtl/sdff_pipe.sv
// DEPTH-stage valid/ready register pipeline using only synchronous-reset, clock-enabled flops.
// Optional macro SDFF_PIPE_SRST_GATED_EN: when defined, reset is qualified by EN.
module sdff_pipe #(
   parameter int               WIDTH        = 1,
   parameter int               DEPTH        = 2,
   parameter bit               CLK_POLARITY = 1'b1,
   parameter logic [WIDTH-1:0] SRST_VALUE   = '0
) (
   input  logic                       CLK,
   input  logic                       SRST,
   input  logic                       EN,
   input  logic                       IN_VALID,
   output logic                       IN_READY,
   input  logic [WIDTH-1:0]           IN_DATA,
   output logic                       OUT_VALID,
   input  logic                       OUT_READY,
   output logic [WIDTH-1:0]           OUT_DATA,
   output logic [$clog2(DEPTH+1)-1:0] COUNT
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]            valid_q;
   logic [DEPTH-1:0]            valid_d;
   logic [DEPTH-1:0][WIDTH-1:0] data_q;
   logic [DEPTH-1:0][WIDTH-1:0] data_d;
   logic [CW-1:0]               count_q;
   logic [CW-1:0]               count_d;
   logic [DEPTH-1:0]            can_load;
   logic                        in_xfer;
   logic                        out_xfer;
   logic                        rst_eff;

`ifdef SDFF_PIPE_SRST_GATED_EN
   assign rst_eff = SRST & EN;
`else
   assign rst_eff = SRST;
`endif

   // A stage can load when it is empty or its own content moves on this edge;
   // this is what lets empty stages behind a stall fill up.
   always_comb begin
      logic chain;
      can_load = '0;
      chain    = ~valid_q[DEPTH-1] | OUT_READY;
      can_load[DEPTH-1] = chain;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         chain       = ~valid_q[i] | chain;
         can_load[i] = chain;
      end
   end

   assign IN_READY  = EN & can_load[0];
   assign in_xfer   = IN_VALID & IN_READY;
   assign out_xfer  = valid_q[DEPTH-1] & OUT_READY & EN;
   assign OUT_VALID = valid_q[DEPTH-1];
   assign OUT_DATA  = data_q[DEPTH-1];
   assign COUNT     = count_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (EN && can_load[0]) begin
         valid_d[0] = IN_VALID;
         data_d[0]  = IN_DATA;
      end
      for (int i = 1; i < DEPTH; i++) begin
         if (EN && can_load[i]) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
         end
      end
   end

   always_comb begin
      count_d = count_q;
      case ({in_xfer, out_xfer})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   generate
      if (CLK_POLARITY) begin : g_pos
         always_ff @(posedge CLK) begin
            if (rst_eff) begin
               valid_q <= '0;
               data_q  <= {DEPTH{SRST_VALUE}};
               count_q <= '0;
            end else if (EN) begin
               valid_q <= valid_d;
               data_q  <= data_d;
               count_q <= count_d;
            end
         end
      end else begin : g_neg
         always_ff @(negedge CLK) begin
            if (rst_eff) begin
               valid_q <= '0;
               data_q  <= {DEPTH{SRST_VALUE}};
               count_q <= '0;
            end else if (EN) begin
               valid_q <= valid_d;
               data_q  <= data_d;
               count_q <= count_d;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sdff_pipe.sv
// Randomized and directed bench for sdff_pipe against a word-position reference model.
// The model tracks each in-flight word and the stage it occupies, oldest first.
module tb_sdff_pipe;

   localparam int               W  = 8;
   localparam int               D  = 3;
   localparam int               CW = $clog2(D + 1);
   localparam logic [W-1:0]     RV = 8'h5A;

   logic          CLK = 1'b0;
   logic          SRST = 1'b0;
   logic          EN = 1'b0;
   logic          IN_VALID = 1'b0;
   logic          IN_READY;
   logic [W-1:0]  IN_DATA = '0;
   logic          OUT_VALID;
   logic          OUT_READY = 1'b0;
   logic [W-1:0]  OUT_DATA;
   logic [CW-1:0] COUNT;

   int n_chk  = 0;
   int n_fail = 0;

   logic [W-1:0] exp_q[$];
   int           pos_q[$];

   sdff_pipe #(.WIDTH(W), .DEPTH(D), .CLK_POLARITY(1'b1), .SRST_VALUE(RV)) dut (
      .CLK(CLK), .SRST(SRST), .EN(EN),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
      .COUNT(COUNT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Each word moves one stage forward unless the word ahead ends up right in front of it.
   task automatic model_advance(input logic push, input logic [W-1:0] d, input logic ordy);
      logic [W-1:0] nd[$];
      int           np[$];
      int           ahead;
      int           p;
      ahead = D;
      for (int k = 0; k < exp_q.size(); k++) begin
         p = pos_q[k];
         if (p == D - 1 && ordy) continue;
         p = (p + 1 < ahead - 1) ? p + 1 : ahead - 1;
         nd.push_back(exp_q[k]);
         np.push_back(p);
         ahead = p;
      end
      if (push) begin
         nd.push_back(d);
         np.push_back(0);
      end
      exp_q = nd;
      pos_q = np;
   endtask

   task automatic step(input logic v, input logic [W-1:0] d, input logic ordy,
                       input logic en, input logic rst);
      logic er;
      logic do_rst;
      logic ov;
      IN_VALID  = v;
      IN_DATA   = d;
      OUT_READY = ordy;
      EN        = en;
      SRST      = rst;
      #1;
      er = en && (exp_q.size() < D || ordy);
      check("in_ready", IN_READY, er);
`ifdef SDFF_PIPE_SRST_GATED_EN
      do_rst = rst && en;
`else
      do_rst = rst;
`endif
      @(posedge CLK);
      #1;
      if (do_rst) begin
         exp_q.delete();
         pos_q.delete();
      end else if (en) begin
         model_advance(v && er, d, ordy);
      end
      ov = (exp_q.size() > 0) && (pos_q[0] == D - 1);
      check("out_valid", OUT_VALID, ov);
      if (ov) check("out_data", OUT_DATA, exp_q[0]);
      else if (do_rst) check("out_data_rst", OUT_DATA, RV);
      check("count", COUNT, exp_q.size());
      @(negedge CLK);
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int k = 0; k < n; k++) step(1'b0, W'($urandom), ordy, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      @(negedge CLK);
      do_reset();
      check("rst_out_valid", OUT_VALID, 1'b0);
      check("rst_out_data", OUT_DATA, RV);
      check("rst_count", COUNT, 0);

      // Stream with latency DEPTH
      step(1'b1, 8'h11, 1'b1, 1'b1, 1'b0);
      step(1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
      step(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
      check("stream_first", {OUT_VALID, OUT_DATA}, {1'b1, 8'h11});
      check("stream_peak", COUNT, 3);
      idle(1, 1'b1);
      check("stream_second", OUT_DATA, 8'h22);
      idle(1, 1'b1);
      check("stream_third", OUT_DATA, 8'h33);
      idle(2, 1'b1);

      // Backpressure, then simultaneous push/pop while full
      do_reset();
      for (int k = 0; k < 3; k++) step(1'b1, W'($urandom), 1'b0, 1'b1, 1'b0);
      check("bp_count", COUNT, 3);
      step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
      check("bp_in_ready", IN_READY, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b1, W'($urandom), 1'b1, 1'b1, 1'b0);
      check("bp_full_flow", COUNT, 3);
      idle(4, 1'b1);

      // Bubble collapse behind a stall
      do_reset();
      step(1'b1, 8'hA1, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b0);
      step(1'b1, 8'hB2, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b0);
      check("bubble_count", COUNT, 2);
      check("bubble_head", {OUT_VALID, OUT_DATA}, {1'b1, 8'hA1});
      idle(1, 1'b1);
      check("bubble_adjacent", {OUT_VALID, OUT_DATA}, {1'b1, 8'hB2});
      idle(2, 1'b1);

      // EN freeze mid-stream
      do_reset();
      step(1'b1, 8'hC1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 8'hC2, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
      check("freeze_count", COUNT, 2);
      step(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
      idle(4, 1'b1);
      check("freeze_drained", COUNT, 0);

      // Reset mid-operation with a push in the reset cycle
      do_reset();
      step(1'b1, 8'hD1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'hD2, 1'b0, 1'b1, 1'b0);
      check("midrst_pre", COUNT, 2);
      step(1'b1, 8'hD3, 1'b1, 1'b1, 1'b1);
      check("midrst_valid", OUT_VALID, 1'b0);
      check("midrst_data", OUT_DATA, RV);
      check("midrst_count", COUNT, 0);

      // Reset while EN is low
      step(1'b1, 8'hE1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'hE2, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef SDFF_PIPE_SRST_GATED_EN
      check("gate_count", COUNT, 2);
`else
      check("gate_count", COUNT, 0);
`endif

      // Random traffic
      do_reset();
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(0, 1)), W'($urandom),
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 9),
              ($urandom_range(0, 49) == 0));
      end
      idle(2 * D + 2, 1'b1);
      check("final_empty", COUNT, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
